// File: rtl/nrx_cpu_ctrl.sv
// nrx_cpu_ctrl
// CPU-side control block for the Namco/Konami Z80 arcade cores. It generates
// the CPU clock enable and holds the addressable single-bit control latch
// (sound trigger, interrupt enable, flip, lamps). It also provides a
// multi-source, maskable, edge-triggered interrupt controller with vector
// generation and INT/NMI routing.
//
// Ports
//   CLK24M     in   1        system clock (24.576 MHz)
//   RESET      in   1        synchronous, active-high reset
//   cen        out  1        CPU clock enable, one CLK24M cycle wide
//   A          in   16       CPU address
//   DO         in   8        CPU write data
//   MREQ_n, IORQ_n, WR_n, M1_n, RFSH_n   in  1  Z80 bus strobes
//   irq_src    in   NSRC     interrupt sources, rising edge requests
//   nmi_mode   in   1        1 = route the request to NMI_n instead of INT_n
//   INT_n      out  1        maskable interrupt request
//   NMI_n      out  1        non-maskable interrupt request
//   vec_oe     out  1        drive vec onto the CPU data bus
//   vec        out  8        interrupt vector
//   latch_q    out  LATCH_N  control latch contents (bit 1 = interrupt enable)
module nrx_cpu_ctrl #(
    parameter int          CEN_DIV    = 8,
    parameter int          LATCH_N    = 8,
    parameter logic [15:0] LATCH_BASE = 16'hA180,
    parameter logic [15:0] MASK_ADDR  = 16'hA1C0,
    parameter int          NSRC       = 2,
    parameter bit          AUTO_ACK   = 1'b1
) (
    input  logic               CLK24M,
    input  logic               RESET,
    output logic               cen,
    input  logic [15:0]        A,
    input  logic [7:0]         DO,
    input  logic               MREQ_n,
    input  logic               IORQ_n,
    input  logic               WR_n,
    input  logic               M1_n,
    input  logic               RFSH_n,
    input  logic [NSRC-1:0]    irq_src,
    input  logic               nmi_mode,
    output logic               INT_n,
    output logic               NMI_n,
    output logic               vec_oe,
    output logic [7:0]         vec,
    output logic [LATCH_N-1:0] latch_q
);

    localparam int CW = $clog2(CEN_DIV);
    localparam int LB = $clog2(LATCH_N);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    // IDLE: no interrupt acknowledge in progress.
    // BUSY: an acknowledge cycle was seen on a cen and has not ended yet.
    typedef enum logic {
        ACK_IDLE,
        ACK_BUSY
    } ack_state_t;

    logic [CW-1:0]   cnt;
    logic            mw;
    logic            iow;
    logic            ack;
    logic            latch_hit;
    logic            ie_write;
    logic            mask_hit;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] src_d;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] active;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   ack_idx;
    logic [7:0]      vreg;
    logic            req;
    logic            ack_done;
    ack_state_t      ack_state;
    ack_state_t      ack_state_next;

    // Free-running divider. CEN_DIV is a power of two, so the counter wraps
    // without an explicit compare.
    always_ff @(posedge CLK24M) begin
        if (RESET) cnt <= '0;
        else       cnt <= cnt + CW'(1);
    end

    assign cen = (cnt == CW'(CEN_DIV / 2 - 1));

    assign mw        = ~MREQ_n & RFSH_n & ~WR_n;
    assign iow       = ~IORQ_n & ~WR_n & M1_n;
    assign ack       = ~IORQ_n & ~M1_n;
    assign latch_hit = mw && (A[15:LB] == LATCH_BASE[15:LB]);
    assign ie_write  = latch_hit && (A[LB-1:0] == LB'(1));
    assign mask_hit  = mw && (A == MASK_ADDR);

    // Masking only gates requests; pending bits collect edges regardless.
    // The lowest-numbered active source has priority.
    assign active = pend & mask;

    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) winner = IW'(i);
        end
    end

    // Acknowledge tracking. The clear of the serviced source happens on the
    // first cen that no longer sees the ack strobe.
    always_ff @(posedge CLK24M) begin
        if (RESET)    ack_state <= ACK_IDLE;
        else if (cen) ack_state <= ack_state_next;
    end

    always_comb begin
        ack_state_next = ack_state;
        ack_done       = 1'b0;
        case (ack_state)
            ACK_IDLE: if (ack) ack_state_next = ACK_BUSY;
            ACK_BUSY: begin
                if (!ack) begin
                    ack_state_next = ACK_IDLE;
                    ack_done       = 1'b1;
                end
            end
            default:  ack_state_next = ACK_IDLE;
        endcase
    end

    // Priority of pending updates: new edges, then the ack clear, then the
    // interrupt-enable write clear, so later clears override a same-cen edge.
    always_comb begin
        pend_next = pend | (irq_src & ~src_d);
        if (AUTO_ACK && ack_done) begin
            for (int i = 0; i < NSRC; i++) begin
                if (IW'(i) == ack_idx) pend_next[i] = 1'b0;
            end
        end
        if (ie_write) pend_next = '0;
    end

    // Bus-visible registers and interrupt state, all advanced on cen only.
    // ack_idx freezes while the ack strobe is held so the vector stays stable.
    always_ff @(posedge CLK24M) begin
        if (RESET) begin
            latch_q <= '0;
            mask    <= '1;
            vreg    <= '0;
            src_d   <= '0;
            pend    <= '0;
            ack_idx <= '0;
        end else if (cen) begin
            if (latch_hit) latch_q[A[LB-1:0]] <= DO[0];
            if (mask_hit)  mask <= DO[NSRC-1:0];
            if (iow)       vreg <= DO;
            src_d <= irq_src;
            pend  <= pend_next;
            if (!ack && (|active)) ack_idx <= winner;
        end
    end

    assign req    = latch_q[1] & (|active);
    assign INT_n  = ~(req & ~nmi_mode);
    assign NMI_n  = ~(req & nmi_mode);
    assign vec_oe = ack;
    assign vec    = vreg + 8'({ack_idx, 1'b0});

endmodule

// File: tb/tb_nrx_cpu_ctrl.sv
// tb_nrx_cpu_ctrl
// Self-checking bench for nrx_cpu_ctrl with default parameters: directed
// bring-up steps followed by randomized bus/interrupt traffic compared with
// a behavioural model of latch, mask, vector register and pending set.
module tb_nrx_cpu_ctrl;

    logic        CLK24M = 1'b0;
    logic        RESET  = 1'b1;
    logic        cen;
    logic [15:0] A      = 16'h0000;
    logic [7:0]  DO     = 8'h00;
    logic        MREQ_n = 1'b1;
    logic        IORQ_n = 1'b1;
    logic        WR_n   = 1'b1;
    logic        M1_n   = 1'b1;
    logic        RFSH_n = 1'b1;
    logic [1:0]  irq_src = 2'b00;
    logic        nmi_mode = 1'b0;
    logic        INT_n;
    logic        NMI_n;
    logic        vec_oe;
    logic [7:0]  vec;
    logic [7:0]  latch_q;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_latch;
    logic [7:0] m_vreg;
    logic [1:0] m_mask;
    logic [1:0] m_pend;

    always #5 CLK24M = ~CLK24M;

    nrx_cpu_ctrl dut (
        .CLK24M   (CLK24M),
        .RESET    (RESET),
        .cen      (cen),
        .A        (A),
        .DO       (DO),
        .MREQ_n   (MREQ_n),
        .IORQ_n   (IORQ_n),
        .WR_n     (WR_n),
        .M1_n     (M1_n),
        .RFSH_n   (RFSH_n),
        .irq_src  (irq_src),
        .nmi_mode (nmi_mode),
        .INT_n    (INT_n),
        .NMI_n    (NMI_n),
        .vec_oe   (vec_oe),
        .vec      (vec),
        .latch_q  (latch_q)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next CLK24M edge that samples cen=1.
    task automatic next_cen();
        int guard;
        guard = 0;
        @(negedge CLK24M);
        while (cen !== 1'b1 && guard < 64) begin
            @(negedge CLK24M);
            guard++;
        end
        if (cen !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL cen_timeout: observed no cen, required cen within 64 cycles");
        end
        @(posedge CLK24M);
        #1;
    endtask

    // One bus write held across exactly one cen; io=1 is an OUT cycle.
    task automatic apply_stimulus(input bit io, input logic [15:0] addr, input logic [7:0] data);
        A  = addr;
        DO = data;
        WR_n = 1'b0;
        if (io) begin
            IORQ_n = 1'b0;
            M1_n   = 1'b1;
        end else begin
            MREQ_n = 1'b0;
        end
        next_cen();
        MREQ_n = 1'b1;
        IORQ_n = 1'b1;
        WR_n   = 1'b1;
    endtask

    // Interrupt acknowledge spanning one cen; the serviced source clears on
    // the cen after the strobe drops.
    task automatic do_ack(input string tag, input logic [7:0] exp_vec);
        repeat (2) next_cen();
        IORQ_n = 1'b0;
        M1_n   = 1'b0;
        #1;
        check_output({tag, "_vec_oe"}, 32'(vec_oe), 32'd1);
        check_output({tag, "_vec"}, 32'(vec), 32'(exp_vec));
        next_cen();
        check_output({tag, "_vec_held"}, 32'(vec), 32'(exp_vec));
        IORQ_n = 1'b1;
        M1_n   = 1'b1;
        #1;
        check_output({tag, "_vec_oe_off"}, 32'(vec_oe), 32'd0);
        next_cen();
    endtask

    function automatic int lowest(input logic [1:0] v);
        for (int i = 0; i < 2; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic model_int_n();
        return !(m_latch[1] && ((m_pend & m_mask) != 2'b00));
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [15:0] addr;
        logic [7:0]  d;
        logic [1:0]  pat;
        int idx;
        int off;

        // Reset state
        repeat (3) @(posedge CLK24M);
        #1;
        check_output("rst_cen", 32'(cen), 32'd0);
        check_output("rst_latch", 32'(latch_q), 32'd0);
        check_output("rst_int_n", 32'(INT_n), 32'd1);
        check_output("rst_nmi_n", 32'(NMI_n), 32'd1);
        check_output("rst_vec_oe", 32'(vec_oe), 32'd0);
        check_output("rst_vec", 32'(vec), 32'd0);
        RESET = 1'b0;

        // First cen lands on the 4th edge after release, then every 8 edges
        n = 0;
        forever begin
            @(negedge CLK24M);
            if (cen === 1'b1 || n > 40) break;
            @(posedge CLK24M);
            n++;
        end
        @(posedge CLK24M);
        n++;
        check_output("first_cen", 32'(n), 32'd4);
        n = 0;
        forever begin
            @(negedge CLK24M);
            if (cen === 1'b1 || n > 40) break;
            @(posedge CLK24M);
            n++;
        end
        @(posedge CLK24M);
        n++;
        #1;
        check_output("cen_period", 32'(n), 32'd8);

        // Latch writes
        apply_stimulus(1'b0, 16'hA184, 8'h01);
        check_output("latch_set4", 32'(latch_q), 32'h10);
        apply_stimulus(1'b0, 16'hA184, 8'h00);
        check_output("latch_clr4", 32'(latch_q), 32'h00);
        apply_stimulus(1'b0, 16'hA188, 8'h01);
        check_output("latch_outside", 32'(latch_q), 32'h00);

        // Single source with ack
        apply_stimulus(1'b0, 16'hA181, 8'h01);
        check_output("ie_set", 32'(latch_q), 32'h02);
        apply_stimulus(1'b1, 16'h0000, 8'hCF);
        irq_src = 2'b01;
        next_cen();
        check_output("src0_int_n", 32'(INT_n), 32'd0);
        check_output("src0_nmi_n", 32'(NMI_n), 32'd1);
        irq_src = 2'b00;
        do_ack("ack_src0", 8'hCF);
        check_output("src0_done_int_n", 32'(INT_n), 32'd1);

        // Two sources on the same cen, served in priority order
        apply_stimulus(1'b1, 16'h0000, 8'h10);
        irq_src = 2'b11;
        next_cen();
        check_output("both_int_n", 32'(INT_n), 32'd0);
        irq_src = 2'b00;
        do_ack("ack_both_first", 8'h10);
        check_output("both_mid_int_n", 32'(INT_n), 32'd0);
        do_ack("ack_both_second", 8'h12);
        check_output("both_done_int_n", 32'(INT_n), 32'd1);

        // Masked source is pending but does not request until unmasked
        apply_stimulus(1'b0, 16'hA1C0, 8'h01);
        irq_src = 2'b10;
        next_cen();
        check_output("masked_int_n", 32'(INT_n), 32'd1);
        irq_src = 2'b00;
        next_cen();
        check_output("masked_hold_int_n", 32'(INT_n), 32'd1);
        apply_stimulus(1'b0, 16'hA1C0, 8'h03);
        check_output("unmask_int_n", 32'(INT_n), 32'd0);
        apply_stimulus(1'b0, 16'hA181, 8'h01);
        check_output("ie_write_clears", 32'(INT_n), 32'd1);

        // IE=0 blocks requests; rewriting IE clears what was pending
        apply_stimulus(1'b0, 16'hA181, 8'h00);
        check_output("ie_off_latch", 32'(latch_q), 32'h00);
        irq_src = 2'b01;
        next_cen();
        check_output("ie_off_int_n", 32'(INT_n), 32'd1);
        irq_src = 2'b00;
        next_cen();
        apply_stimulus(1'b0, 16'hA181, 8'h01);
        check_output("ie_on_cleared", 32'(INT_n), 32'd1);

        // NMI routing, immediate mode switch, clear by IE write
        nmi_mode = 1'b1;
        irq_src  = 2'b01;
        next_cen();
        check_output("nmi_nmi_n", 32'(NMI_n), 32'd0);
        check_output("nmi_int_n", 32'(INT_n), 32'd1);
        irq_src = 2'b00;
        next_cen();
        nmi_mode = 1'b0;
        #1;
        check_output("mode_sw_int_n", 32'(INT_n), 32'd0);
        check_output("mode_sw_nmi_n", 32'(NMI_n), 32'd1);
        nmi_mode = 1'b1;
        #1;
        check_output("mode_back_nmi_n", 32'(NMI_n), 32'd0);
        apply_stimulus(1'b0, 16'hA181, 8'h01);
        check_output("nmi_clear_nmi_n", 32'(NMI_n), 32'd1);
        check_output("nmi_clear_int_n", 32'(INT_n), 32'd1);
        nmi_mode = 1'b0;

        // Randomized traffic against the model
        m_latch = 8'h02;
        m_mask  = 2'b11;
        m_pend  = 2'b00;
        m_vreg  = 8'($urandom);
        apply_stimulus(1'b1, 16'(($urandom)), m_vreg);
        check_output("rnd_start_latch", 32'(latch_q), 32'(m_latch));
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    addr = 16'hA180 + 16'($urandom_range(0, 15));
                    d    = 8'($urandom);
                    apply_stimulus(1'b0, addr, d);
                    off = int'(addr) - 'hA180;
                    if (off < 8) begin
                        m_latch[off] = d[0];
                        if (off == 1) m_pend = 2'b00;
                    end
                    check_output("rnd_latch", 32'(latch_q), 32'(m_latch));
                end
                1: begin
                    d = 8'($urandom);
                    apply_stimulus(1'b0, 16'hA1C0, d);
                    m_mask = d[1:0];
                end
                2: begin
                    d = 8'($urandom);
                    apply_stimulus(1'b1, 16'($urandom), d);
                    m_vreg = d;
                end
                3: begin
                    pat = 2'($urandom_range(1, 3));
                    irq_src = pat;
                    next_cen();
                    m_pend = m_pend | pat;
                    check_output("rnd_pulse_int_n", 32'(INT_n), 32'(model_int_n()));
                    irq_src = 2'b00;
                    next_cen();
                end
                default: begin
                    if ((m_pend & m_mask) != 2'b00) begin
                        idx = lowest(m_pend & m_mask);
                        do_ack("rnd_ack", m_vreg + 8'(2 * idx));
                        m_pend[idx] = 1'b0;
                    end
                end
            endcase
            check_output("rnd_int_n", 32'(INT_n), 32'(model_int_n()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
